btn_event_ctrl: RTL

- Parametrised N-channel button front end for the PPU/CPU board top level. It replaces the per-button debounce instances and the hand-coded scroll hold counters.
- Per channel it provides a 2-FF synchroniser, a debouncer, and a typematic auto-repeat state machine.
- Press/repeat/release events from all channels are merged into a single valid/ready event stream. The MMIO scroll writer (SCY 0xFF42 / SCX 0xFF43) and the future joypad register consume this stream.

---
 rtl/btn_event_pkg.sv | 26 ++
 rtl/btn_channel.sv | 151 +++++++++++++++
 rtl/btn_event_ctrl.sv | 120 ++++++++++++
 3 files changed

// File: rtl/btn_event_pkg.sv
// rtl/btn_event_pkg.sv - shared types and helpers for the button event front end
package btn_event_pkg;

    typedef enum logic [1:0] {
        EVT_NONE    = 2'd0,
        EVT_PRESS   = 2'd1,
        EVT_RELEASE = 2'd2,
        EVT_REPEAT  = 2'd3
    } evt_kind_t;

    typedef enum logic [1:0] {
        RPT_IDLE,
        RPT_DELAY,
        RPT_REPEAT
    } rpt_state_t;

    // Bit positions inside a channel's pending vector
    localparam int PEND_P = 0;
    localparam int PEND_R = 1;
    localparam int PEND_L = 2;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/btn_channel.sv
// rtl/btn_channel.sv - one button: synchroniser, debouncer, typematic repeat FSM, pending events
module btn_channel
    import btn_event_pkg::*;
#(
    parameter int DEBOUNCE_COUNT = 100000,
    parameter int REPEAT_DELAY   = 2097152,
    parameter int REPEAT_PERIOD  = 524288
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      noisy_i,
    input  logic      repeat_en_i,
    input  logic      consume_i,
    input  evt_kind_t consume_kind_i,
    output logic      clean_o,
    output logic [2:0] pend_o,
    output logic      drop_o
);

    localparam int CNT_W = $clog2(DEBOUNCE_COUNT + 1);
    localparam int RPT_W = max_int(1, $clog2(max_int(REPEAT_DELAY, REPEAT_PERIOD)));
    localparam logic [CNT_W-1:0] DB_MAX  = CNT_W'(DEBOUNCE_COUNT);
    localparam logic [RPT_W-1:0] RD_LAST = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] RP_LAST = RPT_W'(REPEAT_PERIOD - 1);

    logic             s1_q, s2_q;
    logic             cand_q, cand_d;
    logic             clean_q, clean_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    rpt_state_t       state_q, state_d;
    logic [RPT_W-1:0] rcnt_q, rcnt_d;
    logic [2:0]       pend_q, pend_d;
    logic             rise, fall;
    logic             raise_p, raise_r, raise_l;
    logic [2:0]       cons, keep;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            cand_q  <= 1'b0;
            clean_q <= 1'b0;
            cnt_q   <= '0;
            state_q <= RPT_IDLE;
            rcnt_q  <= '0;
            pend_q  <= '0;
        end else begin
            s1_q    <= noisy_i;
            s2_q    <= s1_q;
            cand_q  <= cand_d;
            clean_q <= clean_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
            rcnt_q  <= rcnt_d;
            pend_q  <= pend_d;
        end
    end

    always_comb begin
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        clean_d = clean_q;
        if (s2_q != cand_q) begin
            cand_d = s2_q;
            cnt_d  = '0;
        end else if (cnt_q == DB_MAX) begin
            if (clean_q != cand_q) clean_d = cand_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Edges are taken from the debouncer update itself so PRESS lands with clean_o
    assign rise = clean_d & ~clean_q;
    assign fall = ~clean_d & clean_q;

    always_comb begin
        state_d = state_q;
        rcnt_d  = rcnt_q;
        raise_p = 1'b0;
        raise_r = 1'b0;
        raise_l = 1'b0;
        if (fall) begin
            raise_l = 1'b1;
            state_d = RPT_IDLE;
            rcnt_d  = '0;
        end else begin
            case (state_q)
                RPT_IDLE: begin
                    if (rise) begin
                        raise_p = 1'b1;
                        state_d = RPT_DELAY;
                        rcnt_d  = '0;
                    end
                end
                RPT_DELAY: begin
                    if (!repeat_en_i) begin
                        rcnt_d = '0;
                    end else if (rcnt_q == RD_LAST) begin
                        raise_r = 1'b1;
                        state_d = RPT_REPEAT;
                        rcnt_d  = '0;
                    end else begin
                        rcnt_d = rcnt_q + 1'b1;
                    end
                end
                RPT_REPEAT: begin
                    if (!repeat_en_i) begin
                        rcnt_d = '0;
                    end else if (rcnt_q == RP_LAST) begin
                        raise_r = 1'b1;
                        rcnt_d  = '0;
                    end else begin
                        rcnt_d = rcnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = RPT_IDLE;
                    rcnt_d  = '0;
                end
            endcase
        end
    end

    always_comb begin
        cons         = '0;
        cons[PEND_P] = consume_i && (consume_kind_i == EVT_PRESS);
        cons[PEND_R] = consume_i && (consume_kind_i == EVT_REPEAT);
        cons[PEND_L] = consume_i && (consume_kind_i == EVT_RELEASE);
        keep         = pend_q & ~cons;
        pend_d       = keep;
        drop_o       = 1'b0;
        // A press behind an undelivered release would reorder the stream, so it is dropped
        if (raise_p) begin
            if (keep[PEND_P] || keep[PEND_L]) drop_o = 1'b1;
            else                              pend_d[PEND_P] = 1'b1;
        end
        if (raise_r) begin
            if (keep[PEND_R]) drop_o = 1'b1;
            else              pend_d[PEND_R] = 1'b1;
        end
        if (raise_l) begin
            if (keep[PEND_L]) drop_o = 1'b1;
            else              pend_d[PEND_L] = 1'b1;
        end
    end

    assign clean_o = clean_q;
    assign pend_o  = pend_q;

endmodule

// File: rtl/btn_event_ctrl.sv
// rtl/btn_event_ctrl.sv - N-channel button front end merged into one round-robin event stream
module btn_event_ctrl
    import btn_event_pkg::*;
#(
    parameter int NUM_BTNS       = 5,
    parameter int DEBOUNCE_COUNT = 100000,
    parameter int REPEAT_DELAY   = 2097152,
    parameter int REPEAT_PERIOD  = 524288
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_BTNS-1:0]         noisy_in,
    input  logic [NUM_BTNS-1:0]         repeat_en,
    output logic [NUM_BTNS-1:0]         clean_out,
    output logic                        evt_valid,
    input  logic                        evt_ready,
    output logic [$clog2(NUM_BTNS)-1:0] evt_id,
    output logic [1:0]                  evt_kind,
    output logic                        ovf,
    input  logic                        ovf_clr
);

    localparam int ID_W = $clog2(NUM_BTNS);

    logic [2:0]          pend_w [NUM_BTNS];
    logic [NUM_BTNS-1:0] drop_w;
    logic [NUM_BTNS-1:0] consume_w;

    logic                evt_valid_q, evt_valid_d;
    logic [ID_W-1:0]     evt_id_q, evt_id_d;
    evt_kind_t           evt_kind_q, evt_kind_d;
    logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic                ovf_q, ovf_d;

    logic                load;
    logic                found;
    logic [ID_W-1:0]     pick_id;
    evt_kind_t           pick_kind;
    logic [ID_W-1:0]     scan_idx;

    for (genvar g = 0; g < NUM_BTNS; g++) begin : g_ch
        assign consume_w[g] = load && found && (pick_id == ID_W'(g));

        btn_channel #(
            .DEBOUNCE_COUNT (DEBOUNCE_COUNT),
            .REPEAT_DELAY   (REPEAT_DELAY),
            .REPEAT_PERIOD  (REPEAT_PERIOD)
        ) u_ch (
            .clk            (clk),
            .rst_n          (rst_n),
            .noisy_i        (noisy_in[g]),
            .repeat_en_i    (repeat_en[g]),
            .consume_i      (consume_w[g]),
            .consume_kind_i (pick_kind),
            .clean_o        (clean_out[g]),
            .pend_o         (pend_w[g]),
            .drop_o         (drop_w[g])
        );
    end

    assign load = !evt_valid_q || evt_ready;

    // Scan starts one past the last served channel so a busy button cannot starve the rest
    always_comb begin
        found     = 1'b0;
        pick_id   = '0;
        pick_kind = EVT_NONE;
        scan_idx  = '0;
        for (int i = 1; i <= NUM_BTNS; i++) begin
            scan_idx = ID_W'((int'(rr_ptr_q) + i) % NUM_BTNS);
            if (!found && (pend_w[scan_idx] != 3'b000)) begin
                found   = 1'b1;
                pick_id = scan_idx;
                if (pend_w[scan_idx][PEND_P])      pick_kind = EVT_PRESS;
                else if (pend_w[scan_idx][PEND_R]) pick_kind = EVT_REPEAT;
                else                               pick_kind = EVT_RELEASE;
            end
        end
    end

    always_comb begin
        evt_valid_d = evt_valid_q;
        evt_id_d    = evt_id_q;
        evt_kind_d  = evt_kind_q;
        rr_ptr_d    = rr_ptr_q;
        if (load) begin
            evt_valid_d = found;
            if (found) begin
                evt_id_d   = pick_id;
                evt_kind_d = pick_kind;
                rr_ptr_d   = pick_id;
            end
        end
        if (|drop_w)      ovf_d = 1'b1;
        else if (ovf_clr) ovf_d = 1'b0;
        else              ovf_d = ovf_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            evt_valid_q <= 1'b0;
            evt_id_q    <= '0;
            evt_kind_q  <= EVT_NONE;
            rr_ptr_q    <= '0;
            ovf_q       <= 1'b0;
        end else begin
            evt_valid_q <= evt_valid_d;
            evt_id_q    <= evt_id_d;
            evt_kind_q  <= evt_kind_d;
            rr_ptr_q    <= rr_ptr_d;
            ovf_q       <= ovf_d;
        end
    end

    assign evt_valid = evt_valid_q;
    assign evt_id    = evt_id_q;
    assign evt_kind  = evt_kind_q;
    assign ovf       = ovf_q;

endmodule
